// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath/memory.
// Master side is the controller; slave side is the datapath.
interface multicycle_controller_if #(
    parameter int unsigned ALU_OP_W = 4
);
    logic [6:0]          i_operand;
    logic [2:0]          i_funct3;
    logic                i_funct7bit5;
    logic                i_zero;
    logic                i_memReady;
    logic                o_memReq;
    logic                o_memWriteEn;
    logic                o_adrSel;
    logic                o_irWriteEn;
    logic                o_pcWriteEn;
    logic                o_regWriteEn;
    logic [1:0]          o_aluSrcASel;
    logic [1:0]          o_aluSrcBSel;
    logic [1:0]          o_resultSel;
    logic [ALU_OP_W-1:0] o_aluLogicOperation;
    logic                o_fault;

    modport master (
        input  i_operand, i_funct3, i_funct7bit5, i_zero, i_memReady,
        output o_memReq, o_memWriteEn, o_adrSel, o_irWriteEn, o_pcWriteEn, o_regWriteEn,
        output o_aluSrcASel, o_aluSrcBSel, o_resultSel, o_aluLogicOperation, o_fault
    );

    modport slave (
        output i_operand, i_funct3, i_funct7bit5, i_zero, i_memReady,
        input  o_memReq, o_memWriteEn, o_adrSel, o_irWriteEn, o_pcWriteEn, o_regWriteEn,
        input  o_aluSrcASel, o_aluSrcBSel, o_resultSel, o_aluLogicOperation, o_fault
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM with per-access memory timeout and sticky fault.
// Define MULTICYCLE_CONTROLLER_JAL_EN to include the JAL state; otherwise JAL decodes to fault.
module multicycle_controller #(
    parameter int unsigned ALU_OP_W    = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic                     i_clk,
    input logic                     i_rst,
    multicycle_controller_if.master bus
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
`ifdef MULTICYCLE_CONTROLLER_JAL_EN
    localparam logic [6:0] OpJal    = 7'b1101111;
`endif

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b1000;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
`ifdef MULTICYCLE_CONTROLLER_JAL_EN
        StJal,
`endif
        StFault
    } ctrlState;

    ctrlState            stateQ, stateD;
    logic [CntW-1:0]     waitCntQ, waitCntD;

    logic                memReq, memWriteEn, adrSel;
    logic                irWriteEn, pcWriteEn, regWriteEn;
    logic [1:0]          aluSrcASel, aluSrcBSel, resultSel;
    logic [3:0]          aluOp;
    logic                fault;
    logic                memAccess;
    logic                timeout;

    assign timeout = (waitCntQ == CntW'(MEM_TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stateQ   <= StFetch;
            waitCntQ <= '0;
        end else begin
            stateQ   <= stateD;
            waitCntQ <= waitCntD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        waitCntD   = '0;
        memReq     = 1'b0;
        memWriteEn = 1'b0;
        adrSel     = 1'b0;
        irWriteEn  = 1'b0;
        pcWriteEn  = 1'b0;
        regWriteEn = 1'b0;
        aluSrcASel = 2'b00;
        aluSrcBSel = 2'b00;
        resultSel  = 2'b00;
        aluOp      = AluAdd;
        fault      = 1'b0;
        memAccess  = 1'b0;

        unique case (stateQ)
            StFetch: begin
                memReq     = 1'b1;
                memAccess  = 1'b1;
                aluSrcBSel = 2'b10;
                resultSel  = 2'b10;
                irWriteEn  = bus.i_memReady;
                pcWriteEn  = bus.i_memReady;
                stateD     = StDecode;
            end
            StDecode: begin
                aluSrcASel = 2'b01;
                aluSrcBSel = 2'b01;
                case (bus.i_operand)
                    OpLoad, OpStore: stateD = StMemAdr;
                    OpRType:         stateD = StExecR;
                    OpIType:         stateD = StExecI;
                    OpBranch:        stateD = StBranch;
`ifdef MULTICYCLE_CONTROLLER_JAL_EN
                    OpJal:           stateD = StJal;
`endif
                    default:         stateD = StFault;
                endcase
            end
            StMemAdr: begin
                aluSrcASel = 2'b10;
                aluSrcBSel = 2'b01;
                if (bus.i_operand == OpLoad) begin
                    stateD = StMemRead;
                end else if (bus.i_operand == OpStore) begin
                    stateD = StMemWrite;
                end else begin
                    stateD = StFault;
                end
            end
            StMemRead: begin
                memReq    = 1'b1;
                memAccess = 1'b1;
                adrSel    = 1'b1;
                stateD    = StMemWb;
            end
            StMemWb: begin
                resultSel  = 2'b01;
                regWriteEn = 1'b1;
                stateD     = StFetch;
            end
            StMemWrite: begin
                memReq     = 1'b1;
                memWriteEn = 1'b1;
                memAccess  = 1'b1;
                adrSel     = 1'b1;
                stateD     = StFetch;
            end
            StExecR: begin
                aluSrcASel = 2'b10;
                aluOp      = {bus.i_funct7bit5, bus.i_funct3};
                stateD     = StAluWb;
            end
            StExecI: begin
                aluSrcASel = 2'b10;
                aluSrcBSel = 2'b01;
                // Only shifts use funct7 bit 5 (SRLI vs SRAI); it is immediate data otherwise.
                aluOp      = (bus.i_funct3 == 3'b101) ? {bus.i_funct7bit5, bus.i_funct3}
                                                      : {1'b0, bus.i_funct3};
                stateD     = StAluWb;
            end
            StAluWb: begin
                regWriteEn = 1'b1;
                stateD     = StFetch;
            end
            StBranch: begin
                aluSrcASel = 2'b10;
                aluOp      = AluSub;
                stateD     = StFetch;
                case (bus.i_funct3)
                    3'b000:  pcWriteEn = bus.i_zero;
                    3'b001:  pcWriteEn = ~bus.i_zero;
                    default: stateD = StFault;
                endcase
            end
`ifdef MULTICYCLE_CONTROLLER_JAL_EN
            StJal: begin
                aluSrcASel = 2'b01;
                aluSrcBSel = 2'b10;
                pcWriteEn  = 1'b1;
                stateD     = StAluWb;
            end
`endif
            StFault: begin
                fault  = 1'b1;
                stateD = StFault;
            end
            default: stateD = StFault;
        endcase

        // A stalled access holds its state; ready in the last allowed cycle still wins.
        if (memAccess && !bus.i_memReady) begin
            if (timeout) begin
                stateD = StFault;
            end else begin
                stateD   = stateQ;
                waitCntD = waitCntQ + CntW'(1);
            end
        end
    end

    assign bus.o_memReq            = memReq;
    assign bus.o_memWriteEn        = memWriteEn;
    assign bus.o_adrSel            = adrSel;
    assign bus.o_irWriteEn         = irWriteEn;
    assign bus.o_pcWriteEn         = pcWriteEn;
    assign bus.o_regWriteEn        = regWriteEn;
    assign bus.o_aluSrcASel        = aluSrcASel;
    assign bus.o_aluSrcBSel        = aluSrcBSel;
    assign bus.o_resultSel         = resultSel;
    assign bus.o_aluLogicOperation = ALU_OP_W'(aluOp);
    assign bus.o_fault             = fault;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instruction classes, stalls, timeouts,
// fault decode and reset, comparing the packed control outputs against hand-built vectors.
module tb_multicycle_controller;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 i_clk = ~i_clk;

    multicycle_controller_if #(.ALU_OP_W(4)) bus ();

    multicycle_controller #(
        .ALU_OP_W   (4),
        .MEM_TIMEOUT(16)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    // {memReq, memWriteEn, adrSel, irWE, pcWE, regWE, aluA, aluB, resultSel, aluOp, fault}
    logic [16:0] obs;
    assign obs = {bus.o_memReq, bus.o_memWriteEn, bus.o_adrSel, bus.o_irWriteEn,
                  bus.o_pcWriteEn, bus.o_regWriteEn, bus.o_aluSrcASel, bus.o_aluSrcBSel,
                  bus.o_resultSel, bus.o_aluLogicOperation, bus.o_fault};

    localparam logic [16:0] VDecode   = {6'b000000, 2'b01, 2'b01, 2'b00, 4'b0000, 1'b0};
    localparam logic [16:0] VMemAdr   = {6'b000000, 2'b10, 2'b01, 2'b00, 4'b0000, 1'b0};
    localparam logic [16:0] VMemRead  = {6'b101000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0};
    localparam logic [16:0] VMemWb    = {6'b000001, 2'b00, 2'b00, 2'b01, 4'b0000, 1'b0};
    localparam logic [16:0] VMemWrite = {6'b111000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0};
    localparam logic [16:0] VAluWb    = {6'b000001, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0};
    localparam logic [16:0] VFault    = {6'b000000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b1};
`ifdef MULTICYCLE_CONTROLLER_JAL_EN
    localparam logic [16:0] VJal      = {6'b000010, 2'b01, 2'b10, 2'b00, 4'b0000, 1'b0};
`endif

    function automatic logic [16:0] vFetch(input logic r);
        return {1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'b00, 2'b10, 2'b10, 4'b0000, 1'b0};
    endfunction

    function automatic logic [16:0] vExec(input logic isImm, input logic [3:0] op);
        return {6'b000000, 2'b10, (isImm ? 2'b01 : 2'b00), 2'b00, op, 1'b0};
    endfunction

    function automatic logic [16:0] vBranch(input logic p);
        return {4'b0000, p, 1'b0, 2'b10, 2'b00, 2'b00, 4'b1000, 1'b0};
    endfunction

    task automatic checkEq(input string tag, input logic [16:0] got, input logic [16:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with inputs already applied; checks, then advances.
    task automatic cyc(input string tag, input logic [16:0] exp);
        #1;
        checkEq(tag, obs, exp);
        @(negedge i_clk);
    endtask

    task automatic setIn(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic r);
        bus.i_operand    = op;
        bus.i_funct3     = f3;
        bus.i_funct7bit5 = f7;
        bus.i_zero       = z;
        bus.i_memReady   = r;
    endtask

    task automatic doReset();
        i_rst = 1'b1;
        bus.i_memReady = 1'b0;
        @(negedge i_clk);
        cyc("rstHold", vFetch(1'b0));
        i_rst = 1'b0;
        cyc("rstRelease", vFetch(1'b0));
    endtask

    initial begin
        setIn(7'b0, 3'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        cyc("rstIdle", vFetch(1'b0));
        bus.i_memReady = 1'b1;
        cyc("rstReadyGated", vFetch(1'b1));
        i_rst = 1'b0;
        bus.i_memReady = 1'b0;
        cyc("postRst", vFetch(1'b0));

        // lw with ready every cycle
        setIn(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
        cyc("lwFetch", vFetch(1'b1));
        cyc("lwDecode", VDecode);
        cyc("lwMemAdr", VMemAdr);
        cyc("lwMemRead", VMemRead);
        cyc("lwMemWb", VMemWb);

        // sub: R-type funct7bit5=1 funct3=000
        setIn(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
        cyc("subFetch", vFetch(1'b1));
        cyc("subDecode", VDecode);
        cyc("subExecR", vExec(1'b0, 4'b1000));
        cyc("subAluWb", VAluWb);

        // srai: funct3=101 keeps funct7 bit
        setIn(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b1);
        cyc("sraiFetch", vFetch(1'b1));
        cyc("sraiDecode", VDecode);
        cyc("sraiExecI", vExec(1'b1, 4'b1101));
        cyc("sraiAluWb", VAluWb);

        // addi with funct7bit5 set: bit must be dropped
        setIn(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
        cyc("addiFetch", vFetch(1'b1));
        cyc("addiDecode", VDecode);
        cyc("addiExecI", vExec(1'b1, 4'b0000));
        cyc("addiAluWb", VAluWb);

        // Branch taken/not-taken for BNE and BEQ
        setIn(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b1);
        cyc("bneFetch", vFetch(1'b1));
        cyc("bneDecode", VDecode);
        cyc("bneTaken", vBranch(1'b1));
        setIn(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b1);
        cyc("bneFetch2", vFetch(1'b1));
        cyc("bneDecode2", VDecode);
        cyc("bneNotTaken", vBranch(1'b0));
        setIn(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1);
        cyc("beqFetch", vFetch(1'b1));
        cyc("beqDecode", VDecode);
        cyc("beqTaken", vBranch(1'b1));
        setIn(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc("beqFetch2", vFetch(1'b1));
        cyc("beqDecode2", VDecode);
        cyc("beqNotTaken", vBranch(1'b0));

        // Fetch stalled three cycles, completes on the fourth
        setIn(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("fetchStall", vFetch(1'b0));
        bus.i_memReady = 1'b1;
        cyc("fetchDone", vFetch(1'b1));
        bus.i_memReady = 1'b0;
        cyc("fetchStallDecode", VDecode);
        cyc("fetchStallExecR", vExec(1'b0, 4'b0000));
        cyc("fetchStallAluWb", VAluWb);

        // Store: ready arrives in the last allowed cycle, no fault
        setIn(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        cyc("swWinFetch", vFetch(1'b1));
        cyc("swWinDecode", VDecode);
        cyc("swWinMemAdr", VMemAdr);
        bus.i_memReady = 1'b0;
        for (int i = 0; i < 15; i++) cyc("swWinStall", VMemWrite);
        bus.i_memReady = 1'b1;
        cyc("swWinLast", VMemWrite);
        bus.i_memReady = 1'b0;
        cyc("swWinBackToFetch", vFetch(1'b0));
        doReset();

        // Store: ready stuck low, fault after 16 cycles
        setIn(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        cyc("swToFetch", vFetch(1'b1));
        cyc("swToDecode", VDecode);
        cyc("swToMemAdr", VMemAdr);
        bus.i_memReady = 1'b0;
        for (int i = 0; i < 16; i++) cyc("swToStall", VMemWrite);
        cyc("swToFault", VFault);
        bus.i_memReady = 1'b1;
        cyc("swToFaultHold", VFault);
        cyc("swToFaultHold2", VFault);
        doReset();

        // Unsupported branch funct3
        setIn(7'b1100011, 3'b010, 1'b0, 1'b0, 1'b1);
        cyc("bBadFetch", vFetch(1'b1));
        cyc("bBadDecode", VDecode);
        cyc("bBadBranch", vBranch(1'b0));
        cyc("bBadFault", VFault);
        doReset();

        // JAL opcode
        setIn(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc("jalFetch", vFetch(1'b1));
        cyc("jalDecode", VDecode);
`ifdef MULTICYCLE_CONTROLLER_JAL_EN
        cyc("jalJal", VJal);
        cyc("jalAluWb", VAluWb);
        cyc("jalBackFetch", vFetch(1'b1));
`else
        cyc("jalFault", VFault);
        cyc("jalFaultHold", VFault);
`endif
        doReset();

        // Illegal opcode
        setIn(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc("illFetch", vFetch(1'b1));
        cyc("illDecode", VDecode);
        cyc("illFault", VFault);
        doReset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
